pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed EX/MEM pipeline register. Moves one packed payload per cycle between two pipeline stages using a valid/ready handshake. With SKID_EN=1 an optional 2-entry skid buffer keeps full throughput while in_ready stays registered. Supports flush (bubble insertion), single-presentation strobe bits so side-effect commands do not re-fire during a stall, and a saturating stall counter. First instance sits between EX and MEM, with out_ready driven from ~sram_busy.

Parameters:
PAYLOAD_W, 55, width of packed payload (EX/MEM bundle: inst16, res16, store16, wr_en, mem_store, is_mem_cmd, wb_sel, waddr3).
STROBE_MASK, 55'h0 (EX/MEM instance sets the is_mem_cmd bit), payload bits shown only in the first cycle an entry is presented.
SKID_EN, 1, 1 = 2-entry skid with registered in_ready; 0 = single register with combinational in_ready.
STALL_CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous; discards all held entries.
in_valid  in  1  upstream has payload.
in_ready  out  1  block accepts payload this cycle.
in_data  in  PAYLOAD_W  upstream payload.
out_valid  out  1  payload presented downstream.
out_ready  in  1  downstream accepts (= ~sram_busy in the EX/MEM instance).
out_data  out  PAYLOAD_W  presented payload, strobe-gated; all zeros when out_valid=0.
occupancy  out  2  number of held entries (0..2).
stall_cnt  out  STALL_CNT_W  cycles with out_valid & ~out_ready; saturating.

Behaviour:
- Storage: main slot M (mv, md, first) and skid slot S (sv, sd). S exists only when SKID_EN=1.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (mv=0), ONE (mv=1, sv=0), TWO (mv=1, sv=1; SKID_EN=1 only).
- SKID_EN=1: in_ready = ~sv, driven from a flop.
  - EMPTY: in_fire -> ONE, M <= in_data.
  - ONE, out_fire: M <= in_data if in_fire (stay ONE), else -> EMPTY.
  - ONE, ~out_ready, in_fire: S <= in_data -> TWO.
  - TWO, out_fire: M <= S -> ONE. in_fire is impossible because in_ready=0.
  - TWO, ~out_ready: hold.
- SKID_EN=0: in_ready = ~mv | out_ready (combinational). M loads on in_fire; mv clears on out_fire without in_fire.
- Latency: 1 cycle from in_fire to out_valid. Throughput: 1 per cycle while out_ready=1.
- Ordering: strict FIFO. S is never bypassed.
- Strobe gating: out_data = md & ~(STROBE_MASK & {PAYLOAD_W{~first}}).
  - first sets to 1 whenever M is loaded (from input or from S).
  - first clears at the end of any cycle with out_valid & ~out_ready.
  - So a stalled command asserts its strobe in the first cycle only; all other fields hold.
- Bubble: out_valid=0 forces out_data=0, so a NOP is all-zero.
- flush: next cycle mv=sv=first=0. An in_fire in the same cycle is dropped. in_ready still follows its rule that cycle; upstream sees the transfer as accepted and discarded. md/sd are not cleared (masked by the bubble rule).
- Priority: rst > flush > normal operation.
- rst: mv=sv=first=0, md=sd=0, stall_cnt=0, in_ready=1 from the next cycle, out_data=0, occupancy=0. Reset mid-stall discards both entries.
- stall_cnt: increments when out_valid & ~out_ready; holds at 2^STALL_CNT_W-1; flush does not clear it.
- occupancy = mv + sv.

Decomposition:
- Package pipe_pkg holds:
  - EX/MEM field offsets and widths (INST_LSB=39, RES_LSB=23, STORE_LSB=7, WR_EN_BIT=6, MEM_STORE_BIT=5, IS_MEM_CMD_BIT=4, WB_SEL_BIT=3, WADDR_LSB=0).
  - EXMEM_W=55 and EXMEM_STROBE_MASK = 1<<IS_MEM_CMD_BIT.
  - Pack/unpack functions.
- One sub-module, sat_counter (parametrised width, inc, sync rst), used for stall_cnt.

Test Plan:
- Streaming: SKID_EN=1, out_ready=1, in_data=1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later; in_ready=1 throughout; occupancy ≤1.
- Stall fills skid: accept A=0x11, then B=0x22 with out_ready=0 -> occupancy=2, in_ready=0 next cycle; release -> A then B in order; stall_cnt increments by 1 per stalled cycle.
- Strobe gating: EX/MEM packing with is_mem_cmd=1, out_ready=0 for 3 cycles -> bit 4 = 1 in the first cycle and 0 in the next two; inst/res unchanged; on release the entry is seen once.
- Flush while TWO: flush=1 with in_valid=1 -> next cycle out_valid=0, out_data=0, occupancy=0; the flush-cycle input does not appear.
- Reset mid-operation: occupancy=2, rst=1 for 1 cycle -> all outputs 0 and stall_cnt=0; in_ready=1 the following cycle.
- Saturation: STALL_CNT_W=4, stall for 20 cycles -> stall_cnt stops at 15. Also with SKID_EN=0: out_ready=0 while M is full -> in_ready=0 in the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage register family:
//   - EX/MEM payload field offsets/widths and the resulting bundle width
//   - strobe mask for the EX/MEM instance (is_mem_cmd must not re-fire on stall)
//   - occupancy state encoding used by pipe_stage_skid
//   - pack/unpack helpers for the EX/MEM bundle
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int EXMEM_W        = 55;
   localparam int INST_LSB       = 39;
   localparam int RES_LSB        = 23;
   localparam int STORE_LSB      = 7;
   localparam int WR_EN_BIT      = 6;
   localparam int MEM_STORE_BIT  = 5;
   localparam int IS_MEM_CMD_BIT = 4;
   localparam int WB_SEL_BIT     = 3;
   localparam int WADDR_LSB      = 0;
   localparam int FIELD16_W      = 16;
   localparam int WADDR_W        = 3;

   localparam logic [EXMEM_W-1:0] EXMEM_STROBE_MASK =
      {{(EXMEM_W-1){1'b0}}, 1'b1} << IS_MEM_CMD_BIT;

   // Number of held entries; TWO only reachable with the skid slot enabled.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_e;

   typedef struct packed {
      logic [FIELD16_W-1:0] inst;
      logic [FIELD16_W-1:0] res;
      logic [FIELD16_W-1:0] store;
      logic                 wr_en;
      logic                 mem_store;
      logic                 is_mem_cmd;
      logic                 wb_sel;
      logic [WADDR_W-1:0]   waddr;
   } exmem_t;

   function automatic logic [EXMEM_W-1:0] exmem_pack(
      input logic [FIELD16_W-1:0] inst,
      input logic [FIELD16_W-1:0] res,
      input logic [FIELD16_W-1:0] store,
      input logic                 wr_en,
      input logic                 mem_store,
      input logic                 is_mem_cmd,
      input logic                 wb_sel,
      input logic [WADDR_W-1:0]   waddr
   );
      logic [EXMEM_W-1:0] p;
      p = {EXMEM_W{1'b0}};
      p[INST_LSB  +: FIELD16_W] = inst;
      p[RES_LSB   +: FIELD16_W] = res;
      p[STORE_LSB +: FIELD16_W] = store;
      p[WR_EN_BIT]              = wr_en;
      p[MEM_STORE_BIT]          = mem_store;
      p[IS_MEM_CMD_BIT]         = is_mem_cmd;
      p[WB_SEL_BIT]             = wb_sel;
      p[WADDR_LSB +: WADDR_W]   = waddr;
      return p;
   endfunction

   function automatic exmem_t exmem_unpack(input logic [EXMEM_W-1:0] p);
      exmem_t f;
      f.inst       = p[INST_LSB  +: FIELD16_W];
      f.res        = p[RES_LSB   +: FIELD16_W];
      f.store      = p[STORE_LSB +: FIELD16_W];
      f.wr_en      = p[WR_EN_BIT];
      f.mem_store  = p[MEM_STORE_BIT];
      f.is_mem_cmd = p[IS_MEM_CMD_BIT];
      f.wb_sel     = p[WB_SEL_BIT];
      f.waddr      = p[WADDR_LSB +: WADDR_W];
      return f;
   endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value.
//   clk    : clock
//   rst    : synchronous active-high reset, clears the count
//   inc_i  : count one this cycle
//   cnt_o  : current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: increment unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Valid/ready pipeline register with optional 2-entry skid buffer.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : discard all held entries next cycle
//   in_valid / in_ready / in_data    : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and payload
//                                      (strobe bits gated, zero when idle)
//   occupancy  : held entries (0..2)
//   stall_cnt  : saturating count of cycles with out_valid & ~out_ready
// With SKID_EN=1 in_ready comes straight from a flop; the skid slot S absorbs
// the one beat accepted while downstream stalls. With SKID_EN=0 there is a
// single slot and in_ready is combinational.
// -----------------------------------------------------------------------------
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                   PAYLOAD_W   = EXMEM_W,
   parameter logic [PAYLOAD_W-1:0] STROBE_MASK = {PAYLOAD_W{1'b0}},
   parameter bit                   SKID_EN     = 1'b1,
   parameter int                   STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PAYLOAD_W-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PAYLOAD_W-1:0]   out_data,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   logic                 mv_q, mv_d;
   logic [PAYLOAD_W-1:0] md_q, md_d;
   logic                 first_q, first_d;
   logic                 sv_q, sv_d;
   logic [PAYLOAD_W-1:0] sd_q, sd_d;
   logic                 in_ready_q, in_ready_d;

   logic       in_fire;
   logic       out_fire;
   logic       stall;
   occ_state_e state;

   assign in_ready  = SKID_EN ? in_ready_q : (~mv_q | out_ready);
   assign out_valid = mv_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = mv_q & out_ready;
   assign stall     = mv_q & ~out_ready;
   assign occupancy = {1'b0, mv_q} + {1'b0, sv_q};

   // Decode the held-entry state from the two valid bits.
   always_comb begin
      if (mv_q && sv_q) begin
         state = OCC_TWO;
      end else if (mv_q) begin
         state = OCC_ONE;
      end else begin
         state = OCC_EMPTY;
      end
   end

   // Next-state for both slots; flush wins over any transfer this cycle.
   always_comb begin
      mv_d    = mv_q;
      md_d    = md_q;
      first_d = first_q;
      sv_d    = sv_q;
      sd_d    = sd_q;
      if (flush) begin
         // Data registers are left alone; the bubble rule hides them.
         mv_d    = 1'b0;
         sv_d    = 1'b0;
         first_d = 1'b0;
      end else if (SKID_EN) begin
         case (state)
            OCC_EMPTY: begin
               if (in_fire) begin
                  mv_d    = 1'b1;
                  md_d    = in_data;
                  first_d = 1'b1;
               end else begin
                  mv_d    = 1'b0;
               end
            end
            OCC_ONE: begin
               if (out_ready) begin
                  if (in_fire) begin
                     md_d    = in_data;
                     first_d = 1'b1;
                  end else begin
                     mv_d    = 1'b0;
                     first_d = 1'b0;
                  end
               end else begin
                  // Stalled: head has now been shown once; park new beat in S.
                  first_d = 1'b0;
                  if (in_fire) begin
                     sv_d = 1'b1;
                     sd_d = in_data;
                  end else begin
                     sv_d = 1'b0;
                  end
               end
            end
            OCC_TWO: begin
               if (out_ready) begin
                  md_d    = sd_q;
                  sv_d    = 1'b0;
                  first_d = 1'b1;
               end else begin
                  first_d = 1'b0;
               end
            end
            default: begin
               mv_d    = 1'b0;
               sv_d    = 1'b0;
               first_d = 1'b0;
            end
         endcase
      end else begin
         sv_d = 1'b0;
         if (in_fire) begin
            mv_d    = 1'b1;
            md_d    = in_data;
            first_d = 1'b1;
         end else if (out_fire) begin
            mv_d    = 1'b0;
            first_d = 1'b0;
         end else if (stall) begin
            first_d = 1'b0;
         end else begin
            first_d = first_q;
         end
      end
   end

   // in_ready is registered: free exactly when the skid slot will be empty.
   always_comb begin
      in_ready_d = ~sv_d;
   end

   // Slot registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mv_q       <= 1'b0;
         md_q       <= {PAYLOAD_W{1'b0}};
         first_q    <= 1'b0;
         sv_q       <= 1'b0;
         sd_q       <= {PAYLOAD_W{1'b0}};
         in_ready_q <= 1'b1;
      end else begin
         mv_q       <= mv_d;
         md_q       <= md_d;
         first_q    <= first_d;
         sv_q       <= sv_d;
         sd_q       <= sd_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Presented payload: zero when idle, strobe bits only while first is set.
   always_comb begin
      if (mv_q) begin
         out_data = md_q & ~(STROBE_MASK & {PAYLOAD_W{~first_q}});
      end else begin
         out_data = {PAYLOAD_W{1'b0}};
      end
   end

   sat_counter #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (stall),
      .cnt_o (stall_cnt)
   );

endmodule
